// File: rtl/mem_block_banked.sv
// Banked RAM for CNN feature-map/weight storage: one write port, one latency-configurable
// read port with write-first bypass, and a clear engine that initialises every bank.

module mem_block_bank #(
   parameter int RAM_DEPTH = 512,
   parameter int RAM_ADDRW = 9,
   parameter int RAM_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 we,
   input  logic [RAM_ADDRW-1:0] waddr,
   input  logic [RAM_WIDTH-1:0] wdata,
   input  logic                 re,
   input  logic [RAM_ADDRW-1:0] raddr,
   output logic [RAM_WIDTH-1:0] rdata
);
   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) mem[waddr] <= wdata;
   end

   // Synchronous read register; only loads on a read so the output holds between reads.
   always_ff @(posedge clk_i) begin
      if (rst_i)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

module mem_block_banked #(
   parameter int                 NUM_BANKS  = 2,
   parameter int                 RAM_DEPTH  = 512,
   parameter int                 RAM_ADDRW  = 9,
   parameter int                 RAM_WIDTH  = 32,
   parameter int                 BANKW      = 1,
   parameter int                 RD_LATENCY = 1,
   parameter logic [RAM_WIDTH-1:0] CLEAR_VAL = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_req_i,
   output logic                 clr_busy_o,
   input  logic                 wr_en_i,
   input  logic [BANKW-1:0]     wr_bank_i,
   input  logic [RAM_ADDRW-1:0] wr_addr_i,
   input  logic [RAM_WIDTH-1:0] wr_data_i,
   input  logic                 rd_en_i,
   input  logic [BANKW-1:0]     rd_bank_i,
   input  logic [RAM_ADDRW-1:0] rd_addr_i,
   output logic [RAM_WIDTH-1:0] rd_data_o,
   output logic                 rd_valid_o,
   output logic                 oob_err_o
);
   localparam int STAGES = RD_LATENCY;
   localparam logic [RAM_ADDRW-1:0] LAST_ADDR = RAM_ADDRW'(RAM_DEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                 state;
   logic [RAM_ADDRW-1:0]   clr_addr;
   logic                   clr_we;
   logic                   idle;
   logic                   wr_ok, rd_ok, wr_fire, rd_fire;
   logic [STAGES:1]        vld_q;
   logic [STAGES:0]        vld_pipe;
   logic [BANKW-1:0]       sel_q;
   logic                   byp_q;
   logic [RAM_WIDTH-1:0]   byp_data_q;
   logic [RAM_WIDTH-1:0]   rd_data1;
   logic [NUM_BANKS-1:0][RAM_WIDTH-1:0] bank_rd;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= S_CLEAR;
         clr_addr   <= '0;
         clr_busy_o <= 1'b1;
      end else begin
         case (state)
            S_IDLE: if (clr_req_i) begin
               state      <= S_CLEAR;
               clr_addr   <= '0;
               clr_busy_o <= 1'b1;
            end
            S_CLEAR: if (clr_addr == LAST_ADDR) begin
               state      <= S_IDLE;
               clr_busy_o <= 1'b0;
            end else begin
               clr_addr <= clr_addr + 1'b1;
            end
            default: state <= S_CLEAR;
         endcase
      end
   end

   assign idle    = (state == S_IDLE);
   assign clr_we  = (state == S_CLEAR) && !rst_i;
   assign wr_ok   = (32'(wr_addr_i) < RAM_DEPTH) && (32'(wr_bank_i) < NUM_BANKS);
   assign rd_ok   = (32'(rd_addr_i) < RAM_DEPTH) && (32'(rd_bank_i) < NUM_BANKS);
   assign wr_fire = idle && wr_en_i && wr_ok;
   assign rd_fire = idle && rd_en_i && rd_ok;

   always_ff @(posedge clk_i) begin
      if (rst_i) oob_err_o <= 1'b0;
      else if (idle && ((wr_en_i && !wr_ok) || (rd_en_i && !rd_ok))) oob_err_o <= 1'b1;
   end

   genvar b;
   generate
      for (b = 0; b < NUM_BANKS; b++) begin : g_bank
         logic                 we_b;
         logic [RAM_ADDRW-1:0] waddr_b;
         logic [RAM_WIDTH-1:0] wdata_b;

         // Clear and user writes are mutually exclusive, so one write port suffices.
         assign we_b    = clr_we || (wr_fire && (wr_bank_i == BANKW'(b)));
         assign waddr_b = clr_we ? clr_addr : wr_addr_i;
         assign wdata_b = clr_we ? CLEAR_VAL : wr_data_i;

         mem_block_bank #(
            .RAM_DEPTH(RAM_DEPTH),
            .RAM_ADDRW(RAM_ADDRW),
            .RAM_WIDTH(RAM_WIDTH)
         ) u_bank (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .we    (we_b),
            .waddr (waddr_b),
            .wdata (wdata_b),
            .re    (rd_fire && (rd_bank_i == BANKW'(b))),
            .raddr (rd_addr_i),
            .rdata (bank_rd[b])
         );
      end
   endgenerate

   // Bank select and bypass state only move on accepted reads, so rd_data_o holds otherwise.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sel_q      <= '0;
         byp_q      <= 1'b0;
         byp_data_q <= '0;
      end else if (rd_fire) begin
         sel_q      <= rd_bank_i;
         byp_q      <= wr_fire && (wr_bank_i == rd_bank_i) && (wr_addr_i == rd_addr_i);
         byp_data_q <= wr_data_i;
      end
   end

   assign rd_data1 = byp_q ? byp_data_q : bank_rd[sel_q];

   assign vld_pipe = {vld_q, rd_fire};

   always_ff @(posedge clk_i) begin
      if (rst_i) vld_q <= '0;
      else       vld_q <= vld_pipe[STAGES-1:0];
   end

   assign rd_valid_o = vld_pipe[STAGES];

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic [RAM_WIDTH-1:0] rd_data2;
         always_ff @(posedge clk_i) begin
            if (rst_i)            rd_data2 <= '0;
            else if (vld_pipe[1]) rd_data2 <= rd_data1;
         end
         assign rd_data_o = rd_data2;
      end else begin : g_lat1
         assign rd_data_o = rd_data1;
      end
   endgenerate
endmodule

// File: tb/tb_mem_block_banked.sv
// Directed bench: dut_a uses default parameters, dut_b uses RAM_DEPTH=500, RD_LATENCY=2 and a
// non-zero CLEAR_VAL; both share one stimulus stream.

module tb_mem_block_banked;
   logic        clk = 1'b0;
   logic        rst, clr_req, wr_en, rd_en;
   logic [0:0]  wr_bank, rd_bank;
   logic [8:0]  wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic        a_busy, a_valid, a_oob, b_busy, b_valid, b_oob;
   logic [31:0] a_data, b_data;
   int          total = 0;
   int          fails = 0;
   int          na, nb;
   logic        saw_a, saw_b;

   localparam logic [31:0] B_CLR = 32'h0BAD_F00D;

   always #5 clk = ~clk;

   mem_block_banked dut_a (
      .clk_i(clk), .rst_i(rst), .clr_req_i(clr_req), .clr_busy_o(a_busy),
      .wr_en_i(wr_en), .wr_bank_i(wr_bank), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_bank_i(rd_bank), .rd_addr_i(rd_addr),
      .rd_data_o(a_data), .rd_valid_o(a_valid), .oob_err_o(a_oob)
   );

   mem_block_banked #(.RAM_DEPTH(500), .RD_LATENCY(2), .CLEAR_VAL(B_CLR)) dut_b (
      .clk_i(clk), .rst_i(rst), .clr_req_i(clr_req), .clr_busy_o(b_busy),
      .wr_en_i(wr_en), .wr_bank_i(wr_bank), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_bank_i(rd_bank), .rd_addr_i(rd_addr),
      .rd_data_o(b_data), .rd_valid_o(b_valid), .oob_err_o(b_oob)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic quiet();
      clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic wr(input logic b, input logic [8:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
   endtask

   task automatic rd(input logic b, input logic [8:0] a);
      rd_en = 1'b1; rd_bank = b; rd_addr = a;
   endtask

   // Ticks until each DUT drops clr_busy_o; reports the tick index of the first low sample.
   task automatic wait_clear(output int ca, output int cb);
      ca = -1; cb = -1;
      for (int i = 1; i <= 1000; i++) begin
         tick();
         if (ca < 0 && !a_busy) ca = i;
         if (cb < 0 && !b_busy) cb = i;
         if (ca >= 0 && cb >= 0) break;
      end
   endtask

   initial begin
      rst = 1'b1; quiet();
      wr_bank = '0; wr_addr = '0; wr_data = '0; rd_bank = '0; rd_addr = '0;
      tick(); tick();
      chk("rst_a_busy", 32'(a_busy), 1);
      chk("rst_b_busy", 32'(b_busy), 1);
      chk("rst_a_valid", 32'(a_valid), 0);
      chk("rst_a_data", a_data, 0);
      chk("rst_a_oob", 32'(a_oob), 0);
      chk("rst_b_data", b_data, 0);

      // 1: initial clear, then read the top address
      rst = 1'b0;
      wait_clear(na, nb);
      chk("clr1_a_len", na, 512);
      chk("clr1_b_len", nb, 500);
      rd(1'b1, 9'h1FF);
      tick(); quiet();
      chk("t1_a_valid", 32'(a_valid), 1);
      chk("t1_a_data", a_data, 32'h0);
      chk("t1_b_oob", 32'(b_oob), 1);
      chk("t1_b_novalid", 32'(b_valid), 0);
      tick();
      chk("t1_a_pulse", 32'(a_valid), 0);
      chk("t1_b_novalid2", 32'(b_valid), 0);
      rst = 1'b1;
      tick();
      chk("t1_b_oob_rst", 32'(b_oob), 0);
      tick(); rst = 1'b0;
      wait_clear(na, nb);
      chk("clr2_a_len", na, 512);

      // 2: write both banks, read back-to-back
      wr(1'b0, 9'd5, 32'hDEADBEEF);
      tick(); wr(1'b1, 9'd5, 32'h12345678);
      tick(); quiet(); rd(1'b0, 9'd5);
      tick(); rd(1'b1, 9'd5);
      chk("t2_a_v0", 32'(a_valid), 1);
      chk("t2_a_d0", a_data, 32'hDEADBEEF);
      chk("t2_b_v0", 32'(b_valid), 0);
      tick(); quiet();
      chk("t2_a_v1", 32'(a_valid), 1);
      chk("t2_a_d1", a_data, 32'h12345678);
      chk("t2_b_v1", 32'(b_valid), 1);
      chk("t2_b_d1", b_data, 32'hDEADBEEF);
      tick();
      chk("t2_a_v2", 32'(a_valid), 0);
      chk("t2_a_hold", a_data, 32'h12345678);
      chk("t2_b_v2", 32'(b_valid), 1);
      chk("t2_b_d2", b_data, 32'h12345678);
      tick();
      chk("t2_b_v3", 32'(b_valid), 0);
      chk("t2_b_hold", b_data, 32'h12345678);

      // 3: collisions
      wr(1'b0, 9'd7, 32'hA5A5A5A5); rd(1'b0, 9'd7);
      tick(); wr(1'b1, 9'd7, 32'h11112222); rd(1'b0, 9'd7);
      chk("t3_a_same", a_data, 32'hA5A5A5A5);
      tick(); quiet();
      chk("t3_a_other", a_data, 32'hA5A5A5A5);
      chk("t3_b_same", b_data, 32'hA5A5A5A5);
      tick();
      chk("t3_b_other", b_data, 32'hA5A5A5A5);
      rd(1'b1, 9'd7);
      tick(); quiet();
      chk("t3_a_bank1", a_data, 32'h11112222);
      tick();

      // 4: address 505 is in range for dut_a only
      wr(1'b0, 9'd505, 32'hCAFEF00D);
      tick(); quiet();
      chk("t4_b_oob", 32'(b_oob), 1);
      chk("t4_a_oob", 32'(a_oob), 0);
      rd(1'b0, 9'd505);
      tick(); quiet();
      chk("t4_a_rd505", a_data, 32'hCAFEF00D);
      chk("t4_b_novalid", 32'(b_valid), 0);
      tick();
      chk("t4_b_novalid2", 32'(b_valid), 0);

      // 5: clear with a second request and traffic while busy
      clr_req = 1'b1;
      tick(); clr_req = 1'b0;
      chk("t5_a_busy", 32'(a_busy), 1);
      chk("t5_b_busy", 32'(b_busy), 1);
      na = -1; nb = -1; saw_a = 1'b0; saw_b = 1'b0;
      for (int i = 1; i <= 1000; i++) begin
         quiet();
         if (i == 50) begin wr(1'b0, 9'd5, 32'h99999999); rd(1'b0, 9'd5); end
         if (i == 100) clr_req = 1'b1;
         tick();
         if (a_valid && a_busy) saw_a = 1'b1;
         if (b_valid && b_busy) saw_b = 1'b1;
         if (na < 0 && !a_busy) na = i;
         if (nb < 0 && !b_busy) nb = i;
         if (na >= 0 && nb >= 0) break;
      end
      quiet();
      chk("t5_a_len", na, 512);
      chk("t5_b_len", nb, 500);
      chk("t5_a_busy_rd", 32'(saw_a), 0);
      chk("t5_b_busy_rd", 32'(saw_b), 0);
      chk("t5_a_oob", 32'(a_oob), 0);
      chk("t5_b_oob_sticky", 32'(b_oob), 1);
      for (int k = 0; k < 4; k++) begin
         rd(k[0], (k < 2) ? 9'd5 : 9'd7);
         tick(); quiet();
         chk("t5_a_clrval", a_data, 32'h0);
         tick();
         chk("t5_b_clrval", b_data, B_CLR);
      end
      rd(1'b0, 9'd505);
      tick(); quiet();
      chk("t5_a_clr505", a_data, 32'h0);
      tick();

      // 6: reset 200 cycles into a clear
      clr_req = 1'b1;
      tick(); clr_req = 1'b0;
      repeat (200) tick();
      rst = 1'b1;
      tick();
      chk("t6_a_valid_rst", 32'(a_valid), 0);
      chk("t6_b_valid_rst", 32'(b_valid), 0);
      tick();
      chk("t6_b_oob_rst", 32'(b_oob), 0);
      rst = 1'b0;
      wait_clear(na, nb);
      chk("t6_a_len", na, 512);
      chk("t6_b_len", nb, 500);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
